// File: rtl/md5_reply_pkg.sv
// Shared types and defaults for the MD5 reply path.
// The optional reply checksum is enabled with MD5_REPLY_CHECKSUM_EN.
package md5_reply_pkg;

   // Shared with string_process_match: 19 chars = 152-bit message.
   localparam int         MATCH_LEN_DEF   = 19;
   localparam logic [7:0] STATUS_HIT_DEF  = 8'h01;
   localparam logic [7:0] STATUS_MISS_DEF = 8'h00;

`ifdef MD5_REPLY_CHECKSUM_EN
   typedef enum logic [2:0] {
      ST_IDLE, ST_SEND, ST_GUARD, ST_FETCH, ST_CAPTURE, ST_FINISH, ST_CHKSUM
   } state_e;
`else
   typedef enum logic [2:0] {
      ST_IDLE, ST_SEND, ST_GUARD, ST_FETCH, ST_CAPTURE, ST_FINISH
   } state_e;
`endif

   // Which reply byte is currently in txd_data.
   typedef enum logic [2:0] {
      PH_STATUS, PH_POS_HI, PH_POS_LO, PH_CHAR, PH_CHK
   } phase_e;

endpackage

// File: rtl/md5_reply_tx_if.sv
// Search-result, char-pull and UART transmitter signals of the reply path.
interface md5_reply_tx_if;
   logic        proc_done;
   logic        proc_match;
   logic [15:0] proc_byte_pos;
   logic [7:0]  proc_match_char;
   logic        proc_match_char_next;
   logic        txd_busy;
   logic        txd_start;
   logic [7:0]  txd_data;
   logic        reply_busy;
   logic        reply_done;

   // Environment side: search engine, char source and transmitter.
   modport master (
      output proc_done, proc_match, proc_byte_pos, proc_match_char, txd_busy,
      input  proc_match_char_next, txd_start, txd_data, reply_busy, reply_done
   );

   // Reply block side.
   modport slave (
      input  proc_done, proc_match, proc_byte_pos, proc_match_char, txd_busy,
      output proc_match_char_next, txd_start, txd_data, reply_busy, reply_done
   );
endinterface

// File: rtl/md5_reply_tx_uart_byte_sender.sv
// Start/busy handshake with the UART transmitter. A byte is taken when the
// transmitter is idle; the cycle after a start ignores txd_busy because the
// transmitter raises busy one edge late.
module uart_byte_sender (
   input  logic clk,
   input  logic reset,
   input  logic byte_valid,
   output logic byte_ready,
   input  logic txd_busy,
   output logic txd_start
);

   logic start_q, start_d;
   logic guard_q, guard_d;
   logic fire;

   // Accept when idle and out of the guard cycle; a start opens the guard.
   always_comb begin
      byte_ready = !guard_q && !txd_busy;
      fire       = byte_valid && byte_ready;
      start_d    = fire;
      guard_d    = fire;
   end

   // Handshake registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         start_q <= 1'b0;
         guard_q <= 1'b0;
      end else begin
         start_q <= start_d;
         guard_q <= guard_d;
      end
   end

   assign txd_start = start_q;

endmodule

// File: rtl/md5_reply_tx.sv
// Reply sequencer: status byte, then on a hit the byte position and
// MATCH_LEN pulled chars, handed byte by byte to uart_byte_sender.
// MD5_REPLY_CHECKSUM_EN appends an XOR of all sent bytes to every reply.
module md5_reply_tx
   import md5_reply_pkg::*;
#(
   parameter int         MATCH_LEN   = MATCH_LEN_DEF,
   parameter logic [7:0] STATUS_HIT  = STATUS_HIT_DEF,
   parameter logic [7:0] STATUS_MISS = STATUS_MISS_DEF
) (
   input logic           clk,
   input logic           reset,
   md5_reply_tx_if.slave bus
);

   localparam int CNT_W = $clog2(MATCH_LEN + 1);
`ifdef MD5_REPLY_CHECKSUM_EN
   localparam state_e LAST_ST = ST_CHKSUM;
`else
   localparam state_e LAST_ST = ST_FINISH;
`endif

   state_e           state_q, state_d;
   phase_e           phase_q, phase_d;
   logic             match_q, match_d;
   logic [15:0]      pos_q, pos_d;
   logic [7:0]       data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             next_q, next_d;
`ifdef MD5_REPLY_CHECKSUM_EN
   logic [7:0]       chk_q, chk_d;
`endif
   logic             byte_valid, byte_ready;

   assign byte_valid = (state_q == ST_SEND);

   uart_byte_sender u_sender (
      .clk        (clk),
      .reset      (reset),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .txd_busy   (bus.txd_busy),
      .txd_start  (bus.txd_start)
   );

   // State and datapath registers; reset aborts any reply in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         phase_q <= PH_STATUS;
         match_q <= 1'b0;
         pos_q   <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         next_q  <= 1'b0;
`ifdef MD5_REPLY_CHECKSUM_EN
         chk_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         match_q <= match_d;
         pos_q   <= pos_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         next_q  <= next_d;
`ifdef MD5_REPLY_CHECKSUM_EN
         chk_q   <= chk_d;
`endif
      end
   end

   // Next state: new requests only in IDLE; GUARD picks the following byte.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (bus.proc_done) state_d = ST_SEND;
         ST_SEND:    if (byte_ready) state_d = ST_GUARD;
         ST_GUARD: begin
            case (phase_q)
               PH_STATUS: state_d = match_q ? ST_SEND : LAST_ST;
               PH_POS_HI: state_d = ST_SEND;
               PH_POS_LO: state_d = ST_FETCH;
               PH_CHAR:   state_d = (cnt_q < CNT_W'(MATCH_LEN)) ? ST_FETCH : LAST_ST;
               default:   state_d = ST_FINISH;
            endcase
         end
         ST_FETCH:   state_d = ST_CAPTURE;
         ST_CAPTURE: state_d = ST_SEND;
`ifdef MD5_REPLY_CHECKSUM_EN
         ST_CHKSUM:  state_d = ST_SEND;
`endif
         default:    state_d = ST_IDLE;
      endcase
   end

   // Datapath loads and registered pulse/level outputs.
   always_comb begin
      phase_d = phase_q;
      match_d = match_q;
      pos_d   = pos_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
`ifdef MD5_REPLY_CHECKSUM_EN
      chk_d   = chk_q;
`endif
      case (state_q)
         ST_IDLE: begin
`ifdef MD5_REPLY_CHECKSUM_EN
            chk_d = '0;
`endif
            if (bus.proc_done) begin
               match_d = bus.proc_match;
               pos_d   = bus.proc_byte_pos;
               data_d  = bus.proc_match ? STATUS_HIT : STATUS_MISS;
               phase_d = PH_STATUS;
               cnt_d   = '0;
            end
         end
         ST_GUARD: begin
            if (phase_q == PH_STATUS && match_q) begin
               data_d  = pos_q[15:8];
               phase_d = PH_POS_HI;
            end else if (phase_q == PH_POS_HI) begin
               data_d  = pos_q[7:0];
               phase_d = PH_POS_LO;
            end else if (phase_q == PH_POS_LO) begin
               phase_d = PH_CHAR;
            end
         end
         ST_CAPTURE: begin
            data_d = bus.proc_match_char;
            cnt_d  = cnt_q + CNT_W'(1);
         end
`ifdef MD5_REPLY_CHECKSUM_EN
         ST_CHKSUM: begin
            data_d  = chk_q;
            phase_d = PH_CHK;
         end
`endif
         default: ;
      endcase
`ifdef MD5_REPLY_CHECKSUM_EN
      // Fold in each byte as the transmitter accepts it.
      if (byte_valid && byte_ready) chk_d = chk_q ^ data_q;
`endif
      busy_d = (state_d != ST_IDLE) && (state_d != ST_FINISH);
      done_d = (state_d == ST_FINISH);
      next_d = (state_d == ST_FETCH);
   end

   assign bus.txd_data             = data_q;
   assign bus.reply_busy           = busy_q;
   assign bus.reply_done           = done_q;
   assign bus.proc_match_char_next = next_q;

endmodule

// File: tb/tb_md5_reply_tx.sv
// Directed bench for md5_reply_tx with a 10-cycle-per-byte transmitter model
// and a char source answering each pull on the following cycle.
module tb_md5_reply_tx;
   import md5_reply_pkg::*;

   logic clk = 1'b0;
   logic reset;
   md5_reply_tx_if bus ();

   md5_reply_tx dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   string      str = "The quick brown fox";
   logic       stall, char_a, mbusy;
   int         bcnt, cidx;
   logic [7:0] bytes[$];
   int         done_cnt = 0, next_cnt = 0, dbl = 0;
   int         n_chk = 0, n_err = 0;

   assign bus.txd_busy = mbusy | stall;

   // Transmitter: busy rises the edge after start and lasts 10 cycles.
   always @(posedge clk) begin
      if (bus.txd_start) begin
         mbusy <= 1'b1;
         bcnt  <= 10;
      end else if (bcnt > 1) begin
         bcnt  <= bcnt - 1;
      end else begin
         bcnt  <= 0;
         mbusy <= 1'b0;
      end
   end

   // Char source: one char per pull, valid the cycle after the pulse.
   always @(posedge clk) begin
      if (reset) begin
         cidx                <= 0;
         bus.proc_match_char <= 8'h00;
      end else if (bus.proc_match_char_next) begin
         bus.proc_match_char <= char_a ? 8'h41 : 8'(str.getc(cidx));
         cidx                <= (cidx == 18) ? 0 : cidx + 1;
      end
   end

   // Traffic log.
   always @(posedge clk) begin
      if (bus.txd_start) begin
         bytes.push_back(bus.txd_data);
         if (bus.txd_busy) dbl <= dbl + 1;
      end
      if (bus.reply_done)           done_cnt <= done_cnt + 1;
      if (bus.proc_match_char_next) next_cnt <= next_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic request(input logic m, input logic [15:0] pos);
      bus.proc_done     = 1'b1;
      bus.proc_match    = m;
      bus.proc_byte_pos = pos;
      tick();
      bus.proc_done     = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int target);
      int c = 0;
      while (done_cnt < target && c < 3000) begin tick(); c++; end
      chk({tag, "_done"}, done_cnt, target);
      // let the transmitter drain before the next step
      c = 0;
      while (mbusy && c < 50) begin tick(); c++; end
   endtask

   task automatic check_stream(input string tag, input int base, input logic m,
                               input logic [15:0] pos, input logic a);
      logic [7:0] exp_q[$];
      logic [7:0] x;
      exp_q.push_back(m ? 8'h01 : 8'h00);
      if (m) begin
         exp_q.push_back(pos[15:8]);
         exp_q.push_back(pos[7:0]);
         for (int i = 0; i < 19; i++) exp_q.push_back(a ? 8'h41 : 8'(str.getc(i)));
      end
`ifdef MD5_REPLY_CHECKSUM_EN
      x = 8'h00;
      foreach (exp_q[i]) x ^= exp_q[i];
      exp_q.push_back(x);
`endif
      chk({tag, "_len"}, bytes.size() - base, exp_q.size());
      for (int i = 0; i < exp_q.size() && base + i < bytes.size(); i++)
         chk($sformatf("%s_b%0d", tag, i), bytes[base + i], exp_q[i]);
   endtask

   initial begin
      int base, nb, db, c, bad;
      reset = 1'b1; stall = 1'b0; char_a = 1'b0;
      bus.proc_done = 1'b0; bus.proc_match = 1'b0; bus.proc_byte_pos = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk("rst_start", bus.txd_start, 1'b0);
      chk("rst_data",  bus.txd_data, 8'h00);
      chk("rst_busy",  bus.reply_busy, 1'b0);
      chk("rst_done",  bus.reply_done, 1'b0);
      chk("rst_next",  bus.proc_match_char_next, 1'b0);

      // Miss, with first-byte latency
      base = bytes.size(); nb = next_cnt;
      request(1'b0, 16'h5555);
      chk("miss_busy_on", bus.reply_busy, 1'b1);
      tick();
      chk("miss_lat_start", bus.txd_start, 1'b1);
      wait_done("miss", 1);
      check_stream("miss", base, 1'b0, 16'h0, 1'b0);
      chk("miss_next", next_cnt - nb, 0);
      chk("miss_busy_off", bus.reply_busy, 1'b0);

      // Hit
      base = bytes.size(); nb = next_cnt;
      request(1'b1, 16'h1234);
      wait_done("hit", 2);
      check_stream("hit", base, 1'b1, 16'h1234, 1'b0);
      chk("hit_next", next_cnt - nb, 19);
      chk("hit_busy_off", bus.reply_busy, 1'b0);

      // Busy stall at reply start
      base = bytes.size(); db = dbl; bad = 0;
      stall = 1'b1;
      request(1'b1, 16'h1234);
      for (int i = 0; i < 200; i++) begin
         if (bus.txd_start !== 1'b0 || bus.txd_data !== 8'h01) bad++;
         tick();
      end
      chk("stall_nostart", bytes.size() - base, 0);
      chk("stall_data", bad, 0);
      stall = 1'b0;
      wait_done("stall", 3);
      check_stream("stall", base, 1'b1, 16'h1234, 1'b0);
      chk("stall_dbl", dbl - db, 0);

      // Overlapping request during a hit is dropped
      base = bytes.size();
      request(1'b1, 16'h1234);
      repeat (30) tick();
      request(1'b0, 16'hFFFF);
      wait_done("ovl", 4);
      repeat (60) tick();
      chk("ovl_one_done", done_cnt, 4);
      check_stream("ovl", base, 1'b1, 16'h1234, 1'b0);

      // Reset after the 5th char is handed off
      base = bytes.size(); c = 0;
      request(1'b1, 16'h1234);
      while (bytes.size() < base + 8 && c < 2000) begin tick(); c++; end
      chk("rstm_reach", bytes.size() - base, 8);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rstm_start", bus.txd_start, 1'b0);
      chk("rstm_busy",  bus.reply_busy, 1'b0);
      chk("rstm_next",  bus.proc_match_char_next, 1'b0);
      nb = next_cnt; base = bytes.size(); db = done_cnt;
      repeat (60) tick();
      chk("rstm_no_next",  next_cnt - nb, 0);
      chk("rstm_no_bytes", bytes.size() - base, 0);
      chk("rstm_no_done",  done_cnt - db, 0);
      base = bytes.size();
      request(1'b0, 16'h0000);
      wait_done("rstm_miss", db + 1);
      check_stream("rstm_miss", base, 1'b0, 16'h0, 1'b0);

`ifdef MD5_REPLY_CHECKSUM_EN
      // Checksum over a hit of 'A's at position 1
      base = bytes.size(); char_a = 1'b1;
      request(1'b1, 16'h0001);
      wait_done("chk", db + 2);
      check_stream("chk", base, 1'b1, 16'h0001, 1'b1);
      if (bytes.size() >= base + 23) chk("chk_tail", bytes[base + 22], 8'h41);
      else chk("chk_tail_len", bytes.size() - base, 23);
      char_a = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/md5_reply_tx.md
Name: md5_reply_tx

Overview:
- Response path of the MD5 accelerator: turns a finished search result into a UART reply byte stream.
- Sits between string_process_match (proc_done/proc_match/proc_byte_pos/proc_match_char) and async_transmitter (TxD_start/TxD_data/TxD_busy).
- Complements cmd_parser's receive path; owns the txd_* handshake and the proc_match_char_next pull protocol.

Parameters:
- MATCH_LEN, 19, number of matched-string chars sent after a hit (19 chars = 152-bit message).
- STATUS_HIT, 8'h01, status byte sent on match.
- STATUS_MISS, 8'h00, status byte sent on no match.

Ports:
- clk  input  1  system clock (96 MHz domain).
- reset  input  1  synchronous, active-high reset.
- proc_done  input  1  one-cycle pulse: search finished, result inputs valid this cycle.
- proc_match  input  1  1 = hash found.
- proc_byte_pos  input  16  byte position of match.
- proc_match_char  input  8  matched char, valid the cycle after a proc_match_char_next pulse.
- proc_match_char_next  output  1  one-cycle pull request for next matched char.
- txd_busy  input  1  transmitter busy.
- txd_start  output  1  one-cycle pulse: transmit txd_data.
- txd_data  output  8  byte to transmit, held stable from start until busy drops.
- reply_busy  output  1  high from accepted proc_done until last byte handed off.
- reply_done  output  1  one-cycle pulse after the last byte is handed off.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-reply aborts at once. txd_start is 0 from the next edge and no further bytes are sent.
- Reply format:
  - Miss: STATUS_MISS (1 byte).
  - Hit: STATUS_HIT, byte_pos[15:8], byte_pos[7:0], then MATCH_LEN chars in pull order.
- States:
  - IDLE: on proc_done, latch proc_match and proc_byte_pos, load STATUS byte into txd_data, set reply_busy, go to SEND.
  - SEND: if txd_busy==0, pulse txd_start for 1 cycle and go to GUARD; otherwise stay.
  - GUARD: one cycle that ignores txd_busy, covering the transmitter's registered busy rise. Then:
    - Miss, after status: go to FINISH.
    - Hit, after status or POS_HI: load the next pos byte and go to SEND.
    - Hit, after POS_LO or a char with chars remaining: go to FETCH.
    - After the last char: go to FINISH.
  - FETCH: pulse proc_match_char_next for 1 cycle, go to CAPTURE.
  - CAPTURE: txd_data <= proc_match_char, increment char_cnt, go to SEND.
  - FINISH: pulse reply_done, clear reply_busy, go to IDLE.
- Latency: proc_done at edge N gives txd_start high in cycle N+1 at the earliest, when txd_busy is low.
- char_cnt width is clog2(MATCH_LEN+1). Exactly MATCH_LEN next pulses per hit and none on a miss.
- proc_done while reply_busy: ignored (dropped). Latched result is unaffected.
- proc_done in the same cycle as FINISH: ignored. Accepted only in IDLE.
- txd_busy high indefinitely: block waits in SEND; no timeout.
- txd_data changes only in IDLE or CAPTURE or on pos-byte load, never while txd_busy is high after a start.

Optional Feature:
- Macro MD5_REPLY_CHECKSUM_EN.
- Defined: a running XOR of every transmitted reply byte (cleared in IDLE) is appended as one extra byte before FINISH, on both hit and miss. Miss reply = 2 bytes, hit = 4+MATCH_LEN.
- Undefined: no checksum logic, no register, formats exactly as above.

Decomposition:
- md5_reply_pkg holds:
  - state encoding (IDLE, SEND, GUARD, FETCH, CAPTURE, FINISH, plus CHKSUM when enabled);
  - default STATUS_HIT/STATUS_MISS constants;
  - MATCH_LEN default shared with string_process_match.
- One natural sub-module: uart_byte_sender, which owns the SEND/GUARD start/busy handshake and exposes byte_valid/byte_ready to the sequencing FSM.

Test Plan:
- Miss: proc_done with proc_match=0, txd_busy modelled 10 cycles per byte -> exactly one txd_start, txd_data=8'h00, zero proc_match_char_next pulses, reply_done 1 cycle later, reply_busy back to 0.
- Hit: proc_match=1, byte_pos=16'h1234, char source returns "The quick brown fox" -> byte stream 01,12,34 then the 19 ASCII chars in order; 19 next pulses; each char sampled the cycle after its pulse.
- Busy stall: hold txd_busy=1 for 200 cycles at reply start -> no txd_start until busy falls; txd_data stable throughout; never two starts within one busy window.
- Reply overlap: second proc_done (match=0, pos=16'hFFFF) during a hit reply -> ignored; stream identical to the single-hit case; only one reply_done.
- Reset mid-operation: reset asserted after the 5th char -> next cycle txd_start=0, reply_busy=0, no next pulses. A later miss request then replies correctly with 00.
- MD5_REPLY_CHECKSUM_EN: hit with pos=16'h0001 and 19 chars of 8'h41 -> trailing byte = 01^00^01^(19×41) = 8'h41; miss -> 00,00.
